// File: rtl/vive_pkg.sv
// Shared types and constants for the Lighthouse pulse identifier:
// polynomial table, LFSR seed, FSM state encoding and default widths.
package vive_pkg;

  localparam int DEF_TS_WIDTH   = 24;
  localparam int DEF_DATA_WIDTH = 17;

  localparam logic [16:0] LFSR_SEED = 17'h00001;

  localparam logic [16:0] POLY_TABLE [32] = '{
    17'h1D258, 17'h17E04, 17'h1FF6B, 17'h13F67,
    17'h1B9EE, 17'h198D1, 17'h178C7, 17'h18A55,
    17'h15777, 17'h1D911, 17'h15769, 17'h1991F,
    17'h12BD0, 17'h1CF73, 17'h1365D, 17'h197F5,
    17'h194A0, 17'h1B279, 17'h13A34, 17'h1AE41,
    17'h180D4, 17'h17891, 17'h12E64, 17'h17C72,
    17'h19C6D, 17'h13F32, 17'h1AE14, 17'h14E76,
    17'h13C97, 17'h130CB, 17'h13750, 17'h1328B
  };

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CAPTURE,
    ST_SEARCH,
    ST_NEXT,
    ST_DONE
  } mpi_state_e;

endpackage

// File: rtl/lfsr_offset_search.sv
// Steps a Fibonacci LFSR from the seed under one polynomial until it equals
// the target word or the step budget runs out; reports the step count at match.
module lfsr_offset_search
  import vive_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int MAX_STEPS  = 131071
) (
  input  logic                  clk_96MHz,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] word,
  input  logic [DATA_WIDTH-1:0] poly,
  output logic                  done,
  output logic                  found,
  output logic [DATA_WIDTH-1:0] offset
);

  localparam int CW = $clog2(MAX_STEPS + 1);

  logic                  busy_q, busy_d;
  logic [DATA_WIDTH-1:0] lfsr_q, lfsr_d;
  logic [CW-1:0]         step_q, step_d;
  logic                  match, exhausted;

  always_comb begin
    // an all-zero word is unreachable from a non-zero seed, so never report it
    match     = busy_q && (word != '0) && (lfsr_q == word);
    exhausted = busy_q && !match && (step_q == CW'(MAX_STEPS - 1));
    done      = match || exhausted;
    found     = match;
    offset    = DATA_WIDTH'(step_q);

    busy_d = busy_q;
    lfsr_d = lfsr_q;
    step_d = step_q;
    if (start) begin
      busy_d = 1'b1;
      lfsr_d = DATA_WIDTH'(LFSR_SEED);
      step_d = '0;
    end else if (busy_q) begin
      if (done) begin
        busy_d = 1'b0;
      end else begin
        lfsr_d = {lfsr_q[DATA_WIDTH-2:0], ^(lfsr_q & poly)};
        step_d = step_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk_96MHz or posedge reset) begin
    if (reset) begin
      busy_q <= 1'b0;
      lfsr_q <= '0;
      step_q <= '0;
    end else begin
      busy_q <= busy_d;
      lfsr_q <= lfsr_d;
      step_q <= step_d;
    end
  end

endmodule

// File: rtl/multi_pulse_identifier.sv
// Round-robin arbiter over BMC decoder channels that resolves each word's LFSR
// offset and groups pulses within a timestamp window into one acknowledged frame.
//
// state      | meaning
// IDLE       | no frame open; waiting for any decoder word
// CAPTURE    | latch selected word, pulse that decoder's reset, start search
// SEARCH     | LFSR search, walking the polynomial table until fixed/exhausted
// NEXT       | pick next pending in-window channel, or close the frame
// DONE       | frame presented with ready; waits for ack
module multi_pulse_identifier
  import vive_pkg::*;
#(
  parameter int                  NUM_CHANNELS  = 2,
  parameter int                  TS_WIDTH      = DEF_TS_WIDTH,
  parameter int                  DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int                  NUM_POLY      = 2,
  parameter int                  MAX_STEPS     = 131071,
  parameter logic [TS_WIDTH-1:0] WINDOW_TICKS  = TS_WIDTH'(20000),
  parameter int                  FRAME_TIMEOUT = 20000
) (
  input  logic                               clk_96MHz,
  input  logic                               reset,
  input  logic [NUM_CHANNELS-1:0]            data_availible,
  input  logic [NUM_CHANNELS*TS_WIDTH-1:0]   ts_data,
  input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] decoded_data,
  input  logic                               ack,
  output logic [NUM_CHANNELS-1:0]            reset_bmc_decoder,
  output logic [NUM_CHANNELS*DATA_WIDTH-1:0] pulse_id,
  output logic [NUM_CHANNELS-1:0]            id_valid,
  output logic [DATA_WIDTH-1:0]              polynomial,
  output logic [TS_WIDTH-1:0]                frame_ts,
  output logic                               ready,
  output logic                               busy
);

  localparam int CHW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int TOW = $clog2(FRAME_TIMEOUT + 1);

  mpi_state_e                         state_q, state_d;
  logic [CHW-1:0]                     rr_ptr_q, rr_ptr_d;
  logic [CHW-1:0]                     sel_q, sel_d;
  logic [CHW-1:0]                     first_ch_q, first_ch_d;
  logic [TS_WIDTH-1:0]                frame_ts_q, frame_ts_d;
  logic [DATA_WIDTH-1:0]              word_q, word_d;
  logic [NUM_CHANNELS-1:0]            attempted_q, attempted_d;
  logic [NUM_CHANNELS-1:0]            id_valid_q, id_valid_d;
  logic [NUM_CHANNELS*DATA_WIDTH-1:0] pulse_id_q, pulse_id_d;
  logic [DATA_WIDTH-1:0]              poly_q, poly_d;
  logic                               poly_fixed_q, poly_fixed_d;
  logic [4:0]                         poly_idx_q, poly_idx_d;
  logic [TOW-1:0]                     tmo_q, tmo_d;
  logic                               ack_hold_q, ack_hold_d;

  logic                  srch_start, srch_done, srch_found;
  logic [DATA_WIDTH-1:0] srch_offset, cur_poly;
  logic [NUM_CHANNELS-1:0] pending;
  logic [CHW-1:0]        idle_pick, next_pick;
  logic [TS_WIDTH-1:0]   next_dist;
  logic                  tmo_expired, ack_accept;

  function automatic logic [CHW-1:0] rr_pick(input logic [NUM_CHANNELS-1:0] req,
                                             input logic [CHW-1:0] ptr);
    logic [2*NUM_CHANNELS-1:0] rot;
    int off, sum;
    rot = {req, req} >> ptr;
    off = 0;
    for (int o = NUM_CHANNELS - 1; o >= 0; o--) begin
      if (rot[o]) off = o;
    end
    sum = int'(ptr) + off;
    if (sum >= NUM_CHANNELS) sum = sum - NUM_CHANNELS;
    return CHW'(sum);
  endfunction

  assign cur_poly = poly_fixed_q ? poly_q : DATA_WIDTH'(POLY_TABLE[poly_idx_q]);

  lfsr_offset_search #(
    .DATA_WIDTH (DATA_WIDTH),
    .MAX_STEPS  (MAX_STEPS)
  ) u_search (
    .clk_96MHz (clk_96MHz),
    .reset     (reset),
    .start     (srch_start),
    .word      (word_q),
    .poly      (cur_poly),
    .done      (srch_done),
    .found     (srch_found),
    .offset    (srch_offset)
  );

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    sel_d        = sel_q;
    first_ch_d   = first_ch_q;
    frame_ts_d   = frame_ts_q;
    word_d       = word_q;
    attempted_d  = attempted_q;
    id_valid_d   = id_valid_q;
    pulse_id_d   = pulse_id_q;
    poly_d       = poly_q;
    poly_fixed_d = poly_fixed_q;
    poly_idx_d   = poly_idx_q;
    tmo_d        = tmo_q;
    srch_start   = 1'b0;

    pending     = data_availible & ~attempted_q;
    idle_pick   = rr_pick(data_availible, rr_ptr_q);
    next_pick   = rr_pick(pending, rr_ptr_q);
    next_dist   = ts_data[int'(next_pick)*TS_WIDTH +: TS_WIDTH] - frame_ts_q;
    tmo_expired = (tmo_q == '0);
    // a held ack counts once; it must drop before another frame can be taken
    ack_accept  = (state_q == ST_DONE) && ack && !ack_hold_q;
    ack_hold_d  = ack_accept || (ack_hold_q && ack);

    if (state_q != ST_IDLE && !tmo_expired) tmo_d = tmo_q - TOW'(1);

    case (state_q)
      ST_IDLE: begin
        if (|data_availible) begin
          sel_d        = idle_pick;
          first_ch_d   = idle_pick;
          frame_ts_d   = ts_data[int'(idle_pick)*TS_WIDTH +: TS_WIDTH];
          attempted_d  = '0;
          id_valid_d   = '0;
          pulse_id_d   = '0;
          poly_d       = '0;
          poly_fixed_d = 1'b0;
          tmo_d        = TOW'(FRAME_TIMEOUT);
          state_d      = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        word_d             = decoded_data[int'(sel_q)*DATA_WIDTH +: DATA_WIDTH];
        attempted_d[sel_q] = 1'b1;
        poly_idx_d         = '0;
        srch_start         = 1'b1;
        state_d            = ST_SEARCH;
      end
      ST_SEARCH: begin
        if (srch_done) begin
          if (srch_found) begin
            pulse_id_d[int'(sel_q)*DATA_WIDTH +: DATA_WIDTH] = srch_offset;
            id_valid_d[sel_q] = 1'b1;
            if (!poly_fixed_q) begin
              poly_d       = cur_poly;
              poly_fixed_d = 1'b1;
            end
            state_d = ST_NEXT;
          end else if (!poly_fixed_q && (int'(poly_idx_q) < NUM_POLY - 1)) begin
            // restart in the same cycle so each failed polynomial costs exactly MAX_STEPS
            poly_idx_d = poly_idx_q + 5'd1;
            srch_start = 1'b1;
          end else begin
            state_d = ST_NEXT;
          end
        end
      end
      ST_NEXT: begin
        if (&attempted_q) begin
          state_d = ST_DONE;
        end else if (|pending) begin
          if (next_dist <= WINDOW_TICKS) begin
            sel_d   = next_pick;
            state_d = ST_CAPTURE;
          end else begin
            state_d = ST_DONE;
          end
        end else if (tmo_expired) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (ack_accept) begin
          id_valid_d = '0;
          rr_ptr_d   = (int'(first_ch_q) == NUM_CHANNELS - 1) ? '0 : first_ch_q + CHW'(1);
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_96MHz or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      rr_ptr_q     <= '0;
      sel_q        <= '0;
      first_ch_q   <= '0;
      frame_ts_q   <= '0;
      word_q       <= '0;
      attempted_q  <= '0;
      id_valid_q   <= '0;
      pulse_id_q   <= '0;
      poly_q       <= '0;
      poly_fixed_q <= 1'b0;
      poly_idx_q   <= '0;
      tmo_q        <= '0;
      ack_hold_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      sel_q        <= sel_d;
      first_ch_q   <= first_ch_d;
      frame_ts_q   <= frame_ts_d;
      word_q       <= word_d;
      attempted_q  <= attempted_d;
      id_valid_q   <= id_valid_d;
      pulse_id_q   <= pulse_id_d;
      poly_q       <= poly_d;
      poly_fixed_q <= poly_fixed_d;
      poly_idx_q   <= poly_idx_d;
      tmo_q        <= tmo_d;
      ack_hold_q   <= ack_hold_d;
    end
  end

  assign reset_bmc_decoder = (state_q == ST_CAPTURE) ? (NUM_CHANNELS'(1) << sel_q) : '0;
  assign pulse_id          = pulse_id_q;
  assign id_valid          = id_valid_q;
  assign polynomial        = poly_q;
  assign frame_ts          = frame_ts_q;
  assign ready             = (state_q == ST_DONE);
  assign busy              = (state_q != ST_IDLE);

endmodule

// File: tb/tb_multi_pulse_identifier.sv
// Directed bench for multi_pulse_identifier with a small decoder model that
// holds each word until its reset_bmc_decoder pulse.
module tb_multi_pulse_identifier;

  localparam int NCH  = 2;
  localparam int TSW  = 24;
  localparam int DW   = 17;
  localparam int MAXS = 200;
  localparam int TMO  = 600;
  localparam logic [16:0] POLY0 = 17'h1D258;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [NCH-1:0]      da;
  logic [NCH-1:0]      load_en = '0;
  logic [NCH*TSW-1:0]  ts_data = '0;
  logic [NCH*DW-1:0]   dec_data = '0;
  logic                ack = 1'b0;
  logic [NCH-1:0]      rbd;
  logic [NCH*DW-1:0]   pulse_id;
  logic [NCH-1:0]      id_valid;
  logic [DW-1:0]       polynomial;
  logic [TSW-1:0]      frame_ts;
  logic                ready, busy;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int rbd_cnt [NCH];
  int rbd_cyc [NCH];

  always #5 clk = ~clk;

  multi_pulse_identifier #(
    .NUM_CHANNELS (NCH),
    .NUM_POLY     (2),
    .MAX_STEPS    (MAXS),
    .FRAME_TIMEOUT(TMO)
  ) dut (
    .clk_96MHz        (clk),
    .reset            (rst),
    .data_availible   (da),
    .ts_data          (ts_data),
    .decoded_data     (dec_data),
    .ack              (ack),
    .reset_bmc_decoder(rbd),
    .pulse_id         (pulse_id),
    .id_valid         (id_valid),
    .polynomial       (polynomial),
    .frame_ts         (frame_ts),
    .ready            (ready),
    .busy             (busy)
  );

  always @(posedge clk or posedge rst) begin
    if (rst) da <= '0;
    else begin
      for (int i = 0; i < NCH; i++) begin
        if (load_en[i]) da[i] <= 1'b1;
        else if (rbd[i]) da[i] <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    cyc++;
    for (int i = 0; i < NCH; i++) begin
      if (rbd[i]) begin
        rbd_cnt[i]++;
        rbd_cyc[i] = cyc;
      end
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic post(input int ch, input logic [DW-1:0] w, input logic [TSW-1:0] t);
    @(negedge clk);
    ts_data[ch*TSW +: TSW] = t;
    dec_data[ch*DW +: DW]  = w;
    load_en[ch] = 1'b1;
    @(negedge clk);
    load_en[ch] = 1'b0;
  endtask

  task automatic wait_ready(input string tag, input int max_cyc);
    for (int i = 0; i < max_cyc && !ready; i++) @(negedge clk);
    check_eq({tag, "_ready"}, ready, 1);
  endtask

  task automatic do_ack(input string tag);
    @(negedge clk);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    check_eq({tag, "_ack_ready"}, ready, 0);
    check_eq({tag, "_ack_valid"}, id_valid, 0);
  endtask

  function automatic logic [16:0] lfsr_after(input logic [16:0] poly, input int k);
    logic [16:0] l;
    l = 17'h00001;
    for (int i = 0; i < k; i++) l = {l[15:0], ^(l & poly)};
    return l;
  endfunction

  function automatic int golden_offset(input logic [16:0] poly, input logic [16:0] w, input int budget);
    logic [16:0] l;
    l = 17'h00001;
    for (int k = 0; k < budget; k++) begin
      if (w != 0 && l == w) return k;
      l = {l[15:0], ^(l & poly)};
    end
    return 0;
  endfunction

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [16:0] w6;
    int          exp6;

    repeat (3) @(negedge clk);
    check_eq("rst_ready", ready, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_valid", id_valid, 0);
    check_eq("rst_pid", pulse_id, 0);
    check_eq("rst_poly", polynomial, 0);
    check_eq("rst_fts", frame_ts, 0);
    check_eq("rst_rbd", rbd, 0);
    rst = 1'b0;

    // single channel, seed word
    post(0, 17'h00001, 24'h9c388);
    wait_ready("t1", 2000);
    check_eq("t1_pid", pulse_id, 0);
    check_eq("t1_valid", id_valid, 2'b01);
    check_eq("t1_fts", frame_ts, 24'h9c388);
    check_eq("t1_poly", polynomial, POLY0);
    check_eq("t1_rbd0", rbd_cnt[0], 1);
    check_eq("t1_rbd1", rbd_cnt[1], 0);
    do_ack("t1");

    // two channels, distance 6864
    post(0, 17'h00001, 24'h9c388);
    repeat (5) @(negedge clk);
    post(1, 17'h00002, 24'h9de58);
    wait_ready("t2", 2000);
    check_eq("t2_pid", pulse_id, {17'd1, 17'd0});
    check_eq("t2_valid", id_valid, 2'b11);
    check_eq("t2_poly", polynomial, POLY0);
    check_eq("t2_fts", frame_ts, 24'h9c388);
    check_eq("t2_rbd1", rbd_cnt[1], 1);
    do_ack("t2");

    // timestamp wrap: ch1 first at FFFF00, ch0 at 000100
    post(1, 17'h00004, 24'hFFFF00);
    repeat (5) @(negedge clk);
    post(0, 17'h00011, 24'h000100);
    wait_ready("t3", 2000);
    check_eq("t3_pid", pulse_id, {17'd2, 17'd4});
    check_eq("t3_valid", id_valid, 2'b11);
    check_eq("t3_fts", frame_ts, 24'hFFFF00);
    do_ack("t3");

    // distance exactly WINDOW_TICKS is inside
    post(0, 17'h00001, 24'h200000);
    post(1, 17'h00008, 24'h204E20);
    wait_ready("t4a", 2000);
    check_eq("t4a_valid", id_valid, 2'b11);
    check_eq("t4a_pid", pulse_id, {17'd3, 17'd0});
    do_ack("t4a");

    // distance WINDOW_TICKS+1 splits into two frames
    post(0, 17'h00008, 24'h100000);
    repeat (5) @(negedge clk);
    post(1, 17'h00002, 24'h104E21);
    wait_ready("t4", 2000);
    check_eq("t4_valid", id_valid, 2'b01);
    check_eq("t4_pid", pulse_id, {17'd0, 17'd3});
    check_eq("t4_fts", frame_ts, 24'h100000);
    check_eq("t4_da1", da[1], 1);
    check_eq("t4_rbd1", rbd_cnt[1], 3);
    do_ack("t4");
    wait_ready("t4b", 2000);
    check_eq("t4b_valid", id_valid, 2'b10);
    check_eq("t4b_pid", pulse_id, {17'd1, 17'd0});
    check_eq("t4b_fts", frame_ts, 24'h104E21);
    check_eq("t4b_rbd1", rbd_cnt[1], 4);
    do_ack("t4b");

    // word 0 exhausts both polynomials before the next channel is captured
    post(0, 17'h00000, 24'h300000);
    repeat (3) @(negedge clk);
    post(1, 17'h00001, 24'h300010);
    wait_ready("t5", 3000);
    check_eq("t5_valid", id_valid, 2'b10);
    check_eq("t5_pid", pulse_id, 0);
    check_eq("t5_poly", polynomial, POLY0);
    check_eq("t5_gap", rbd_cyc[1] - rbd_cyc[0], 2 * MAXS + 2);
    check_eq("t5_rbd0", rbd_cnt[0], 6);
    do_ack("t5");

    // asynchronous reset in the middle of a search
    post(0, 17'h00000, 24'h123456);
    repeat (30) @(negedge clk);
    check_eq("t6_pre_busy", busy, 1);
    check_eq("t6_pre_fts", frame_ts, 24'h123456);
    rst = 1'b1;
    #1;
    check_eq("t6_rst_busy", busy, 0);
    check_eq("t6_rst_fts", frame_ts, 0);
    check_eq("t6_rst_ready", ready, 0);
    check_eq("t6_rst_rbd", rbd, 0);
    @(negedge clk);
    rst = 1'b0;
    w6   = lfsr_after(POLY0, 123);
    exp6 = golden_offset(POLY0, w6, MAXS);
    post(1, w6, 24'h000500);
    wait_ready("t6", 2000);
    check_eq("t6_pid1", pulse_id[2*DW-1:DW], exp6);
    check_eq("t6_pid0", pulse_id[DW-1:0], 0);
    check_eq("t6_valid", id_valid, 2'b10);
    check_eq("t6_poly", polynomial, POLY0);
    check_eq("t6_fts", frame_ts, 24'h000500);
    check_eq("t6_rbd0", rbd_cnt[0], 7);
    check_eq("t6_rbd1", rbd_cnt[1], 6);
    do_ack("t6");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
